uart_rx_fifo: RTL and testbench

Parametrised UART receiver for the Metron peripheral set; it supersedes the fixed 8N1 receiver. It adds configurable frame format, 3-sample majority voting, false-start rejection, framing, parity and overrun detection, and a small output FIFO with a valid/ready handshake. It sits between the pad-side serial input and the bus-side consumer, such as the SoC register block or a DMA engine.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_fifo.sv | 52 +++++
 rtl/uart_rx_fifo.sv | 146 ++++++++++++++
 tb/tb_uart_rx_fifo.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the Metron UART: receiver state encoding and parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_rx_state_e;

  // Frames carry at most 9 data bits; narrower words are zero-extended by the caller.
  function automatic logic uart_parity(input logic [8:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Small synchronous FIFO with registered storage; head word is read combinationally.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [AW:0]      r_count;
  logic             w_push, w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];

  // A full FIFO still accepts a push when the head leaves on the same cycle.
  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_wdata;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with majority vote and error detection, feeding uart_fifo.
// Define UART_RX_PARITY_EN to expect a parity bit after the data bits.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = 16,
  parameter int DATA_BITS      = 8,
  parameter int STOP_BITS      = 1,
  parameter int PARITY_ODD     = 0,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          in_serial,
  output logic [DATA_BITS-1:0]          out_data,
  output logic                          out_valid,
  input  logic                          in_ready,
  output logic [$clog2(FIFO_DEPTH):0]   out_count,
  output logic                          out_frame_err,
  output logic                          out_parity_err,
  output logic                          out_overrun
);
  localparam int H  = CLOCKS_PER_BIT / 2;
  localparam int PW = $clog2(CLOCKS_PER_BIT);
  localparam logic [PW-1:0] PH_LAST = PW'(CLOCKS_PER_BIT - 1);
`ifdef UART_RX_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  logic                 r_sync1, r_sync2, r_hist;
  uart_rx_state_e       r_state;
  logic [PW-1:0]        r_phase;
  logic [3:0]           r_bitcnt;
  logic                 r_stopcnt;
  logic                 r_s0, r_s1;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_stop_bad, r_par_bad;
  logic                 r_frame_err, r_parity_err, r_overrun;

  logic       w_fall, w_dec_pt, w_dec, w_final, w_frame_bad, w_par_fail, w_good;
  logic       w_full, w_empty;
  logic [8:0] w_shift_ext;

  assign w_fall      = r_hist & ~r_sync2;
  assign w_dec_pt    = (r_phase == PW'(H + 1));
  assign w_dec       = (r_s0 & r_s1) | (r_s0 & r_sync2) | (r_s1 & r_sync2);
  assign w_final     = (r_state == STOP) & w_dec_pt & (r_stopcnt == 1'(STOP_BITS - 1));
  assign w_frame_bad = r_stop_bad | ~w_dec;
  // Constant-false when parity is not compiled in, so the checker folds away.
  assign w_par_fail  = PAR_EN & r_par_bad;
  assign w_good      = w_final & ~w_frame_bad & ~w_par_fail;
  assign w_shift_ext = 9'(r_shift);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync1      <= 1'b1;
      r_sync2      <= 1'b1;
      r_hist       <= 1'b1;
      r_state      <= IDLE;
      r_phase      <= '0;
      r_bitcnt     <= '0;
      r_stopcnt    <= 1'b0;
      r_s0         <= 1'b1;
      r_s1         <= 1'b1;
      r_shift      <= '0;
      r_stop_bad   <= 1'b0;
      r_par_bad    <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_sync1      <= in_serial;
      r_sync2      <= r_sync1;
      r_hist       <= r_sync2;
      r_frame_err  <= w_final & w_frame_bad;
      r_parity_err <= w_final & ~w_frame_bad & w_par_fail;
      r_overrun    <= w_good & w_full & ~in_ready;

      if (r_phase == PW'(H - 1)) r_s0 <= r_sync2;
      if (r_phase == PW'(H))     r_s1 <= r_sync2;

      // The edge-detect cycle is phase 0, so the first START cycle is phase 1.
      if (r_state == IDLE) r_phase <= w_fall ? PW'(1) : '0;
      else                 r_phase <= (r_phase == PH_LAST) ? '0 : r_phase + 1'b1;

      case (r_state)
        IDLE:  if (w_fall) r_state <= START;
        START: if (w_dec_pt) begin
          if (w_dec) r_state <= IDLE;
          else begin
            r_state  <= DATA;
            r_bitcnt <= '0;
          end
        end
        DATA: if (w_dec_pt) begin
          r_shift <= {w_dec, r_shift[DATA_BITS-1:1]};
          if (r_bitcnt == 4'(DATA_BITS - 1)) begin
            r_bitcnt   <= '0;
            r_stopcnt  <= 1'b0;
            r_stop_bad <= 1'b0;
            r_state    <= PAR_EN ? PARITY : STOP;
          end else begin
            r_bitcnt <= r_bitcnt + 4'd1;
          end
        end
        PARITY: if (w_dec_pt) begin
          r_par_bad <= w_dec ^ uart_parity(w_shift_ext, PARITY_ODD != 0);
          r_state   <= STOP;
        end
        // A good frame leaves at the decision phase so the next start edge is not missed.
        STOP: if (w_dec_pt) begin
          if (w_final) r_state <= w_frame_bad ? BREAK : IDLE;
          else begin
            r_stop_bad <= r_stop_bad | ~w_dec;
            r_stopcnt  <= 1'b1;
          end
        end
        BREAK:   if (r_sync2) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  uart_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (w_good),
    .i_wdata (r_shift),
    .i_pop   (in_ready),
    .o_rdata (out_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (out_count)
  );

  assign out_valid      = ~w_empty;
  assign out_frame_err  = r_frame_err;
  assign out_parity_err = r_parity_err;
  assign out_overrun    = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: latency, FIFO/overrun, false start, break, parity, reset.
module tb_uart_rx_fifo;
  localparam int CPB = 16, DB = 8, SB = 1, DEPTH = 4;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NBITS = 1 + DB + PB + SB;
  localparam int LAT   = 2 + (NBITS - 1) * CPB + CPB / 2 + 2;

  logic          clk = 1'b0, resetn = 1'b0, in_serial = 1'b1, in_ready = 1'b0;
  logic [DB-1:0] out_data;
  logic          out_valid, out_frame_err, out_parity_err, out_overrun;
  logic [2:0]    out_count;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLOCKS_PER_BIT (CPB),
    .DATA_BITS      (DB),
    .STOP_BITS      (SB),
    .PARITY_ODD     (0),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .in_serial      (in_serial),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .in_ready       (in_ready),
    .out_count      (out_count),
    .out_frame_err  (out_frame_err),
    .out_parity_err (out_parity_err),
    .out_overrun    (out_overrun)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed pops and pulse tallies, sampled mid-cycle.
  logic [DB-1:0] popq[$];
  int pop_cyc = 0, fe_n = 0, pe_n = 0, ov_n = 0;
  always @(negedge clk) if (resetn) begin
    if (out_valid && in_ready) begin
      popq.push_back(out_data);
      pop_cyc <= cyc;
    end
    fe_n <= fe_n + int'(out_frame_err);
    pe_n <= pe_n + int'(out_parity_err);
    ov_n <= ov_n + int'(out_overrun);
  end

  int n_cmp = 0, n_bad = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int frame_cyc = 0;
  task automatic send(input logic [7:0] d, input logic stop_v, input logic par_v);
    frame_cyc = cyc;
    in_serial = 1'b0;
    tick(CPB);
    for (int i = 0; i < DB; i++) begin
      in_serial = d[i];
      tick(CPB);
    end
    if (PB == 1) begin
      in_serial = par_v;
      tick(CPB);
    end
    for (int i = 0; i < SB; i++) begin
      in_serial = stop_v;
      tick(CPB);
    end
  endtask

  int n0, e0, f0, p0, o0;
  logic [7:0] w;

  initial begin
    tick(3);
    check("rst_valid", out_valid, 0);
    check("rst_count", out_count, 0);
    check("rst_data",  out_data, 0);
    check("rst_errs",  {out_frame_err, out_parity_err, out_overrun}, 0);
    resetn = 1'b1;
    tick(4);

    // Single frame, latency and data
    in_ready = 1'b1;
    n0 = popq.size(); e0 = fe_n + pe_n + ov_n;
    w = 8'hA5;
    send(w, 1'b1, ^w);
    tick(2 * CPB);
    check("a5_pops", popq.size() - n0, 1);
    check("a5_data", popq[popq.size()-1], 8'hA5);
    check("a5_lat",  pop_cyc - frame_cyc, LAT);
    check("a5_errs", fe_n + pe_n + ov_n - e0, 0);

    // Fill, overrun, drain
    in_ready = 1'b0;
    o0 = ov_n;
    for (int k = 1; k <= 5; k++) begin
      w = 8'(k);
      send(w, 1'b1, ^w);
    end
    tick(2 * CPB);
    check("full_count", out_count, 4);
    check("full_ovr",   ov_n - o0, 1);
    check("full_valid", out_valid, 1);
    check("full_head",  out_data, 8'h01);
    n0 = popq.size();
    in_ready = 1'b1;
    tick(4);
    in_ready = 1'b0;
    tick(1);
    check("drain_pops", popq.size() - n0, 4);
    for (int i = 0; i < 4; i++) check("drain_data", popq[n0+i], 32'(i + 1));
    check("drain_count", out_count, 0);
    in_ready = 1'b1;

    // False start glitch
    n0 = popq.size(); e0 = fe_n + pe_n + ov_n;
    in_serial = 1'b0;
    tick(4);
    in_serial = 1'b1;
    tick(3 * CPB);
    check("glitch_pops",  popq.size() - n0, 0);
    check("glitch_errs",  fe_n + pe_n + ov_n - e0, 0);
    check("glitch_count", out_count, 0);
    w = 8'h3C;
    send(w, 1'b1, ^w);
    tick(2 * CPB);
    check("after_glitch_pops", popq.size() - n0, 1);
    check("after_glitch_data", popq[popq.size()-1], 8'h3C);

    // Frame error followed by a long break
    n0 = popq.size(); f0 = fe_n;
    w = 8'h55;
    send(w, 1'b0, ^w);
    tick(40 * CPB);
    in_serial = 1'b1;
    tick(2 * CPB);
    check("brk_fe",    fe_n - f0, 1);
    check("brk_pops",  popq.size() - n0, 0);
    check("brk_count", out_count, 0);
    w = 8'h0F;
    send(w, 1'b1, ^w);
    tick(2 * CPB);
    check("after_brk_pops", popq.size() - n0, 1);
    check("after_brk_data", popq[popq.size()-1], 8'h0F);

`ifdef UART_RX_PARITY_EN
    n0 = popq.size(); p0 = pe_n;
    send(8'h07, 1'b1, 1'b1);
    tick(2 * CPB);
    check("par_good_pops", popq.size() - n0, 1);
    check("par_good_data", popq[popq.size()-1], 8'h07);
    check("par_good_pe",   pe_n - p0, 0);
    send(8'h07, 1'b1, 1'b0);
    tick(2 * CPB);
    check("par_bad_pe",   pe_n - p0, 1);
    check("par_bad_pops", popq.size() - n0, 1);
`endif

    // Reset during data bit 4 with a word waiting in the FIFO
    in_ready = 1'b0;
    w = 8'h99;
    send(w, 1'b1, ^w);
    tick(CPB);
    check("pre_rst_count", out_count, 1);
    in_serial = 1'b0;
    tick(CPB + 4 * CPB + CPB / 2);
    resetn = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_count", out_count, 0);
    check("mid_rst_data",  out_data, 0);
    check("mid_rst_errs",  {out_frame_err, out_parity_err, out_overrun}, 0);
    in_serial = 1'b1;
    tick(3);
    resetn   = 1'b1;
    in_ready = 1'b1;
    tick(2 * CPB);
    n0 = popq.size(); e0 = fe_n + pe_n + ov_n;
    w = 8'hC3;
    send(w, 1'b1, ^w);
    tick(2 * CPB);
    check("post_rst_pops", popq.size() - n0, 1);
    check("post_rst_data", popq[popq.size()-1], 8'hC3);
    check("post_rst_errs", fe_n + pe_n + ov_n - e0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
